icache_miss_merge: RTL

Miss-merging stage that sits directly downstream of the round-robin request arbiter in the cluster instruction cache. It takes the single arbitrated miss stream, line address plus requesting core, and keeps a small table of outstanding refills. A miss to a line that is already outstanding is merged into that table entry instead of issuing a second refill. When a refill response returns, the line is broadcast once to every core waiting on it.

---
 rtl/icache_miss_merge.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/icache_miss_merge.sv
// Outstanding-refill table for the cluster icache: merges misses to the same
// line, issues one refill per line and broadcasts the returned line to all waiters.
module icache_miss_merge #(
  parameter int NumCores = 4,
  parameter int NumEntries = 4,
  parameter int AddrWidth = 32,
  parameter int LineWidth = 128,
  localparam int CoreIdWidth = (NumCores > 1) ? $clog2(NumCores) : 1,
  localparam int IdWidth = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [CoreIdWidth-1:0] req_core_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output logic [AddrWidth-1:0]   refill_addr_o,
  output logic [IdWidth-1:0]     refill_id_o,
  output logic                   refill_valid_o,
  input  logic                   refill_ready_i,
  input  logic [IdWidth-1:0]     rsp_id_i,
  input  logic [LineWidth-1:0]   rsp_data_i,
  input  logic                   rsp_valid_i,
  output logic [NumCores-1:0]    core_rsp_valid_o,
  output logic [AddrWidth-1:0]   core_rsp_addr_o,
  output logic [LineWidth-1:0]   core_rsp_data_o,
  output logic                   busy_o
);

  logic [NumEntries-1:0] valid_q, valid_d;
  logic [NumEntries-1:0] issued_q, issued_d;
  logic [AddrWidth-1:0]  addr_q [NumEntries];
  logic [AddrWidth-1:0]  addr_d [NumEntries];
  logic [NumCores-1:0]   wait_q [NumEntries];
  logic [NumCores-1:0]   wait_d [NumEntries];
  logic                  lock_q, lock_d;
  logic [IdWidth-1:0]    lock_id_q, lock_id_d;
  logic [NumCores-1:0]   core_rsp_valid_q, core_rsp_valid_d;
  logic [AddrWidth-1:0]  core_rsp_addr_q, core_rsp_addr_d;
  logic [LineWidth-1:0]  core_rsp_data_q, core_rsp_data_d;

  logic [NumEntries-1:0] hit_vec;
  logic                  hit_any, free_any, pend_any;
  logic [IdWidth-1:0]    hit_idx, free_idx, pend_idx, pres_idx;
  logic [NumCores-1:0]   req_oh;
  logic                  req_acc, rsp_ok, rsp_hit, hs;

  // Descending scan leaves the lowest matching index in each *_idx.
  always_comb begin
    hit_vec  = '0;
    hit_idx  = '0;
    free_idx = '0;
    pend_idx = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      hit_vec[i] = valid_q[i] && (addr_q[i] == req_addr_i);
      if (hit_vec[i]) hit_idx = IdWidth'(i);
      if (!valid_q[i]) free_idx = IdWidth'(i);
      if (valid_q[i] && !issued_q[i]) pend_idx = IdWidth'(i);
    end
  end

  assign hit_any  = |hit_vec;
  assign free_any = ~&valid_q;
  assign pend_any = |(valid_q & ~issued_q);

  assign req_ready_o = !flush_i && (hit_any || free_any);
  assign req_oh      = NumCores'(1) << req_core_i;
  assign req_acc     = req_valid_i && req_ready_o;

  // A presented entry stays on the port until accepted.
  assign pres_idx       = lock_q ? lock_id_q : pend_idx;
  assign refill_valid_o = lock_q || pend_any;
  assign refill_addr_o  = addr_q[pres_idx];
  assign refill_id_o    = pres_idx;
  assign hs             = refill_valid_o && refill_ready_i;

  assign rsp_ok  = rsp_valid_i && valid_q[rsp_id_i] && issued_q[rsp_id_i];
  assign rsp_hit = req_acc && hit_any && rsp_ok && (hit_idx == rsp_id_i);

  always_comb begin
    valid_d          = valid_q;
    issued_d         = issued_q;
    addr_d           = addr_q;
    wait_d           = wait_q;
    lock_d           = refill_valid_o && !refill_ready_i;
    lock_id_d        = pres_idx;
    core_rsp_valid_d = '0;
    core_rsp_addr_d  = core_rsp_addr_q;
    core_rsp_data_d  = core_rsp_data_q;
    if (flush_i) begin
      for (int i = 0; i < NumEntries; i++) begin
        wait_d[i] = '0;
        if (!issued_q[i] && !(refill_valid_o && pres_idx == IdWidth'(i)))
          valid_d[i] = 1'b0;
      end
    end
    if (hs) issued_d[pres_idx] = 1'b1;
    if (rsp_ok) begin
      valid_d[rsp_id_i]  = 1'b0;
      issued_d[rsp_id_i] = 1'b0;
      wait_d[rsp_id_i]   = '0;
      core_rsp_valid_d   = wait_q[rsp_id_i] | (rsp_hit ? req_oh : '0);
      core_rsp_addr_d    = addr_q[rsp_id_i];
      core_rsp_data_d    = rsp_data_i;
    end
    if (req_acc) begin
      if (hit_any) begin
        if (!rsp_hit) wait_d[hit_idx] = wait_q[hit_idx] | req_oh;
      end else begin
        valid_d[free_idx]  = 1'b1;
        issued_d[free_idx] = 1'b0;
        addr_d[free_idx]   = req_addr_i;
        wait_d[free_idx]   = req_oh;
      end
    end
    if (flush_i) core_rsp_valid_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q          <= '0;
      issued_q         <= '0;
      lock_q           <= 1'b0;
      lock_id_q        <= '0;
      core_rsp_valid_q <= '0;
      core_rsp_addr_q  <= '0;
      core_rsp_data_q  <= '0;
      for (int i = 0; i < NumEntries; i++) begin
        addr_q[i] <= '0;
        wait_q[i] <= '0;
      end
    end else begin
      valid_q          <= valid_d;
      issued_q         <= issued_d;
      addr_q           <= addr_d;
      wait_q           <= wait_d;
      lock_q           <= lock_d;
      lock_id_q        <= lock_id_d;
      core_rsp_valid_q <= core_rsp_valid_d;
      core_rsp_addr_q  <= core_rsp_addr_d;
      core_rsp_data_q  <= core_rsp_data_d;
    end
  end

  assign core_rsp_valid_o = core_rsp_valid_q;
  assign core_rsp_addr_o  = core_rsp_addr_q;
  assign core_rsp_data_o  = core_rsp_data_q;
  assign busy_o           = |valid_q;

`ifndef SYNTHESIS
  // Responses must target an entry whose refill was actually issued.
  rsp_target_ok: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_valid_i |-> (valid_q[rsp_id_i] && issued_q[rsp_id_i]));
`endif

endmodule
